// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin sharing of one seven-segment display and
// the status LEDs between two requesters. Each grant shows the captured hex
// digit for HOLD_CYCLES cycles, then a one-cycle blank gap follows in which
// done pulses to the owner if its hold ran to completion.
// SEG and LED must be at least 8 bits wide; any bits above 7 are driven 0.
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int NBITS_TOP   = 8
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic [3:0]           digit_a,
  input  logic [3:0]           digit_b,
  output logic                 gnt_a,
  output logic                 gnt_b,
  output logic                 done_a,
  output logic                 done_b,
  output logic [NBITS_TOP-1:0] SEG,
  output logic [NBITS_TOP-1:0] LED
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHOW_A = 2'b01,
    SHOW_B = 2'b10,
    GAP    = 2'b11
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    digit, digit_next;
  logic          last_b, last_b_next;     // 1 when B held the last grant
  logic          done_a_next, done_b_next;
  logic          gnt_a_next, gnt_b_next;
  logic [7:0]    seg8_next;
  logic [3:0]    cnt4_next;
  logic [NBITS_TOP-1:0] seg_next, led_next;

  // Hex digit to active-high segments {g,f,e,d,c,b,a}; bit 7 left clear.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      4'hF: s = 8'h71;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // The LED field carries the counter zero-extended or truncated to 4 bits.
  generate
    if (CW >= 4) begin : g_cnt_trunc
      assign cnt4_next = cnt_next[3:0];
    end else begin : g_cnt_ext
      assign cnt4_next = {{(4-CW){1'b0}}, cnt_next};
    end
  endgenerate

  // State, datapath and output registers; outputs load their precomputed next values.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= CNT_ZERO;
      digit  <= 4'h0;
      last_b <= 1'b1;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      SEG    <= '0;
      LED    <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      digit  <= digit_next;
      last_b <= last_b_next;
      gnt_a  <= gnt_a_next;
      gnt_b  <= gnt_b_next;
      done_a <= done_a_next;
      done_b <= done_b_next;
      SEG    <= seg_next;
      LED    <= led_next;
    end
  end

  // Next-state logic: arbitration in IDLE/GAP, hold counting and abort in SHOW.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    digit_next  = digit;
    last_b_next = last_b;
    done_a_next = 1'b0;
    done_b_next = 1'b0;
    case (state)
      IDLE, GAP: begin
        // A wins when alone, or on a tie when B was served last.
        if (req_a && (!req_b || last_b)) begin
          state_next  = SHOW_A;
          digit_next  = digit_a;
          cnt_next    = CNT_ZERO;
          last_b_next = 1'b0;
        end else if (req_b) begin
          state_next  = SHOW_B;
          digit_next  = digit_b;
          cnt_next    = CNT_ZERO;
          last_b_next = 1'b1;
        end else begin
          state_next = IDLE;
          cnt_next   = CNT_ZERO;
        end
      end
      SHOW_A: begin
        if (!req_a) begin
          state_next = GAP;
          cnt_next   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_next  = GAP;
          cnt_next    = CNT_ZERO;
          done_a_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      SHOW_B: begin
        if (!req_b) begin
          state_next = GAP;
          cnt_next   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_next  = GAP;
          cnt_next    = CNT_ZERO;
          done_b_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Output logic: derive grants, segment pattern and status word from the next state.
  always_comb begin
    gnt_a_next = (state_next == SHOW_A);
    gnt_b_next = (state_next == SHOW_B);
    case (state_next)
      SHOW_A:  seg8_next = seg_decode(digit_next);
      SHOW_B:  seg8_next = seg_decode(digit_next) | 8'h80;
      default: seg8_next = 8'h00;
    endcase
    seg_next      = '0;
    seg_next[7:0] = seg8_next;
    led_next      = '0;
    led_next[7:0] = {cnt4_next, state_next, gnt_b_next, gnt_a_next};
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: a HOLD_CYCLES=4 and a HOLD_CYCLES=1 instance
// share all stimulus; a behavioural model checks both every cycle and
// literal expectations pin the test-plan scenarios.
module tb_seg_display_arbiter;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [3:0] digit_a = 4'h0, digit_b = 4'h0;

  logic       gnt_a0, gnt_b0, done_a0, done_b0;
  logic [7:0] seg0, led0;
  logic       gnt_a1, gnt_b1, done_a1, done_b1;
  logic [7:0] seg1, led1;

  int errors = 0;
  int checks = 0;

  always #5 clk_2 = ~clk_2;

  seg_display_arbiter #(.HOLD_CYCLES(4), .NBITS_TOP(8)) dut (
    .clk_2(clk_2), .reset(reset), .req_a(req_a), .req_b(req_b),
    .digit_a(digit_a), .digit_b(digit_b),
    .gnt_a(gnt_a0), .gnt_b(gnt_b0), .done_a(done_a0), .done_b(done_b0),
    .SEG(seg0), .LED(led0));

  seg_display_arbiter #(.HOLD_CYCLES(1), .NBITS_TOP(8)) dut1 (
    .clk_2(clk_2), .reset(reset), .req_a(req_a), .req_b(req_b),
    .digit_a(digit_a), .digit_b(digit_b),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .done_a(done_a1), .done_b(done_b1),
    .SEG(seg1), .LED(led1));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 nobody showing, 1 A showing, 2 B showing
  logic [7:0] font [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  int   hold_of [2] = '{4, 1};
  int   m_owner [2];
  int   m_shown [2];   // cycles already shown before the current one
  bit   m_gap   [2];
  int   m_done  [2];   // 0 none, 1 A, 2 B
  int   m_cap   [2];
  int   m_last  [2];   // 1 A, 2 B

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0; m_shown[i] = 0; m_gap[i] = 1'b0;
      m_done[i] = 0; m_cap[i] = 0; m_last[i] = 2;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (m_owner[i] != 0) begin
        bit still = (m_owner[i] == 1) ? req_a : req_b;
        if (!still) begin
          m_done[i] = 0; m_owner[i] = 0; m_gap[i] = 1'b1; m_shown[i] = 0;
        end else if (m_shown[i] + 1 == hold_of[i]) begin
          m_done[i] = m_owner[i]; m_owner[i] = 0; m_gap[i] = 1'b1; m_shown[i] = 0;
        end else begin
          m_shown[i]++;
        end
      end else begin
        m_gap[i] = 1'b0; m_done[i] = 0; m_shown[i] = 0;
        if (req_a && req_b) m_owner[i] = (m_last[i] == 1) ? 2 : 1;
        else if (req_a)     m_owner[i] = 1;
        else if (req_b)     m_owner[i] = 2;
        else                m_owner[i] = 0;
        if (m_owner[i] != 0) begin
          m_last[i] = m_owner[i];
          m_cap[i]  = (m_owner[i] == 1) ? int'(digit_a) : int'(digit_b);
        end
      end
    end
  endtask

  task automatic model_compare(input int i, input logic ga, input logic gb,
                               input logic da, input logic db,
                               input logic [7:0] seg, input logic [7:0] led);
    int exp_seg, phase, exp_led;
    exp_seg = (m_owner[i] == 1) ? int'(font[m_cap[i]]) :
              (m_owner[i] == 2) ? int'(font[m_cap[i]]) + 128 : 0;
    phase   = (m_owner[i] != 0) ? m_owner[i] : (m_gap[i] ? 3 : 0);
    exp_led = (m_shown[i] % 16) * 16 + phase * 4 +
              ((m_owner[i] == 2) ? 2 : 0) + ((m_owner[i] == 1) ? 1 : 0);
    check($sformatf("model%0d gnt_a", i), int'(ga), (m_owner[i] == 1) ? 1 : 0);
    check($sformatf("model%0d gnt_b", i), int'(gb), (m_owner[i] == 2) ? 1 : 0);
    check($sformatf("model%0d done_a", i), int'(da), (m_done[i] == 1) ? 1 : 0);
    check($sformatf("model%0d done_b", i), int'(db), (m_done[i] == 2) ? 1 : 0);
    check($sformatf("model%0d SEG", i), int'(seg), exp_seg);
    check($sformatf("model%0d LED", i), int'(led), exp_led);
  endtask

  // Compare process: advance the model for the edge just passed, then check both DUTs.
  initial begin
    model_reset();
    forever begin
      @(negedge clk_2);
      if (reset) model_reset();
      else model_step();
      model_compare(0, gnt_a0, gnt_b0, done_a0, done_b0, seg0, led0);
      model_compare(1, gnt_a1, gnt_b1, done_a1, done_b1, seg1, led1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk_2);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  logic [7:0] seq2  [11] = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h00,
                             8'h86, 8'h86, 8'h86, 8'h86, 8'h00, 8'h3F};
  logic       dn2a  [11] = '{0,0,0,0,1,0,0,0,0,0,0};
  logic       dn2b  [11] = '{0,0,0,0,0,0,0,0,0,1,0};
  logic [7:0] seq6  [6]  = '{8'h3F, 8'h00, 8'h86, 8'h00, 8'h3F, 8'h00};
  logic       dn6a  [6]  = '{0,1,0,0,0,1};
  logic       dn6b  [6]  = '{0,0,0,1,0,0};

  initial begin
    // Reset state
    tick();
    check("reset SEG", int'(seg0), 0);
    check("reset LED", int'(led0), 0);

    // 1: single requester A, digit 2
    req_a = 1'b1; digit_a = 4'h2; reset = 1'b0;
    tick();
    check("t1 gnt_a", int'(gnt_a0), 1);
    check("t1 SEG", int'(seg0), 8'h5B);
    check("t1 LED", int'(led0), 8'h05);
    for (int k = 0; k < 3; k++) tick();
    tick();
    check("t1 gap SEG", int'(seg0), 8'h00);
    check("t1 gap done_a", int'(done_a0), 1);
    check("t1 gap LED", int'(led0), 8'h0C);
    req_a = 1'b0;
    tick();
    check("t1 idle done_a", int'(done_a0), 0);

    // 2 and 6: both requesting from reset, digits 0 and 1
    pulse_reset();
    req_a = 1'b1; req_b = 1'b1; digit_a = 4'h0; digit_b = 4'h1; reset = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("t2 SEG[%0d]", k), int'(seg0), int'(seq2[k]));
      check($sformatf("t2 done_a[%0d]", k), int'(done_a0), int'(dn2a[k]));
      check($sformatf("t2 done_b[%0d]", k), int'(done_b0), int'(dn2b[k]));
      if (k < 6) begin
        check($sformatf("t6 SEG[%0d]", k), int'(seg1), int'(seq6[k]));
        check($sformatf("t6 done_a[%0d]", k), int'(done_a1), int'(dn6a[k]));
        check($sformatf("t6 done_b[%0d]", k), int'(done_b1), int'(dn6b[k]));
      end
    end

    // 3: digit change during hold is ignored
    pulse_reset();
    req_b = 1'b1; digit_b = 4'hE; reset = 1'b0;
    tick();
    check("t3 SEG c0", int'(seg0), 8'hF9);
    digit_b = 4'h3;
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("t3 SEG c%0d", k), int'(seg0), 8'hF9);
    end
    tick();
    check("t3 gap done_b", int'(done_b0), 1);
    req_b = 1'b0;
    tick();

    // 4: abort after two show cycles
    pulse_reset();
    req_a = 1'b1; digit_a = 4'h7; reset = 1'b0;
    tick();
    tick();
    check("t4 LED mid", int'(led0), 8'h15);
    req_a = 1'b0;
    tick();
    check("t4 abort done_a", int'(done_a0), 0);
    check("t4 abort LED", int'(led0), 8'h0C);
    tick();
    check("t4 idle LED", int'(led0), 8'h00);

    // 5: asynchronous reset during SHOW_B
    pulse_reset();
    req_b = 1'b1; digit_b = 4'h5; reset = 1'b0;
    tick();
    tick();
    check("t5 pre SEG", int'(seg0), 8'hED);
    @(posedge clk_2);
    #2;
    reset = 1'b1;
    #1;
    check("t5 async SEG", int'(seg0), 0);
    check("t5 async LED", int'(led0), 0);
    check("t5 async gnt_b", int'(gnt_b0), 0);
    check("t5 async done", int'(done_b0) + int'(done_a0), 0);
    req_a = 1'b1; digit_a = 4'h9;
    tick();
    reset = 1'b0;
    tick();
    check("t5 first gnt_a", int'(gnt_a0), 1);
    check("t5 first gnt_b", int'(gnt_b0), 0);
    check("t5 first SEG", int'(seg0), 8'h6F);

    // Mixed request/digit stream, checked by the model only
    for (int k = 0; k < 40; k++) begin
      req_a   = ((k % 7) != 3);
      req_b   = ((k % 5) != 0);
      digit_a = 4'(k);
      digit_b = 4'(15 - (k % 16));
      tick();
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Time-shares the board's single seven-segment display (SEG) and status LEDs between two requesters, A and B.
- Each requester raises a request and presents a 4-bit hex digit. The block grants the display with round-robin fairness and shows the captured digit for a fixed number of clk_2 cycles.
- After each hold it inserts a one-cycle blank gap and pulses done to the owner.
- Sits between lab datapath sources (switch logic, counters) and the SEG/LED pins in top.

Parameters:
- HOLD_CYCLES, 4: display cycles per grant; legal range ≥ 1.
- NBITS_TOP, 8: width of SEG and LED.

Ports:
- clk_2  in  1  system clock (divided board clock).
- reset  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A wants the display.
- req_b  in  1  requester B wants the display.
- digit_a  in  4  hex value from A.
- digit_b  in  4  hex value from B.
- gnt_a  out  1  A currently owns the display.
- gnt_b  out  1  B currently owns the display.
- done_a  out  1  one-cycle pulse: A's hold completed normally.
- done_b  out  1  one-cycle pulse: B's hold completed normally.
- SEG  out  NBITS_TOP  segment drive; bit 7 is the decimal point.
- LED  out  NBITS_TOP  status word.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SHOW_A, SHOW_B, GAP.
- Internal registers: captured digit (4 bits), hold counter (clog2(HOLD_CYCLES) bits, minimum 1), last_owner (1 bit).
- Reset, asserted at any time and effective immediately:
  - state = IDLE; all outputs 0, so SEG blank.
  - hold counter = 0; last_owner = B, so A wins the first tie.
- Arbitration is evaluated on every rising edge while in IDLE or GAP:
  - Only req_a → SHOW_A.
  - Only req_b → SHOW_B.
  - Both → the one that is not last_owner.
  - Neither → IDLE.
- On a grant edge:
  - Capture digit_x and clear the counter.
  - Set gnt_x = 1 and SEG = decode(digit_x).
  - Set last_owner = x.
  - Latency: request sampled at edge k; gnt and SEG valid after edge k.
- In SHOW_x, each edge with req_x high:
  - If counter == HOLD_CYCLES-1 → GAP with done_x = 1. Otherwise counter += 1.
  - Result: gnt_x is high for exactly HOLD_CYCLES cycles.
- In SHOW_x, an edge with req_x low (abort):
  - → GAP with done_x = 0.
  - No pre-emption by the other requester; it waits for GAP arbitration.
- GAP lasts exactly one cycle:
  - gnt_a = gnt_b = 0; SEG = 0x00.
  - done_x high only if the hold completed normally.
- done is never high in any state other than GAP.
- Digit changes during SHOW are ignored, because the captured value is displayed.
- Decode, digits 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- SEG[7] = 1 while B owns the display; 0 otherwise.
- LED bit fields:
  - LED[0] = gnt_a.
  - LED[1] = gnt_b.
  - LED[3:2] = state (IDLE=00, SHOW_A=01, SHOW_B=10, GAP=11).
  - LED[7:4] = hold counter, zero-extended and truncated to 4 bits.
- HOLD_CYCLES = 1 edge case: SHOW lasts one cycle; done is asserted in the following GAP.
- Back-to-back operation with both requests held:
  - Sequence: A(HOLD), GAP, B(HOLD), GAP, A, ...
  - Fairness guarantee: no requester waits more than HOLD_CYCLES+1 cycles after becoming eligible.
- Reset mid-SHOW: return to IDLE and blank the display; no done pulse.

Test Plan (HOLD_CYCLES = 4 unless stated):
1. Reset released, req_a = 1, digit_a = 2.
   - Next edge: gnt_a = 1, SEG = 0x5B, LED = 0x05.
   - 4 cycles later: GAP with SEG = 0x00, done_a = 1 for 1 cycle, LED[3:2] = 11.
2. req_a and req_b both high from reset, digit_a = 0, digit_b = 1.
   - Grant order A, B, A, ...
   - SEG sequence: 3F ×4, 00, 86 ×4, 00, 3F ...
   - done pulses alternate.
3. req_b = 1, digit_b = 0xE; change digit_b to 3 mid-hold.
   - SEG stays 0xF9 for all 4 cycles.
4. req_a dropped after 2 SHOW cycles.
   - Next edge: GAP with done_a = 0.
   - Then IDLE, with LED = 0x00 if no request is pending.
5. Assert reset asynchronously (between edges) during SHOW_B.
   - SEG, LED, gnt and done all go to 0 immediately.
   - After release with both requests high: A is granted first.
6. HOLD_CYCLES = 1, both requesters high.
   - Pattern: gnt_a, GAP, gnt_b, GAP; each gnt lasts 1 cycle; done_x high in every GAP.
